// File: rtl/mips_cpu_state_sequencer.sv
// Multi-cycle MIPS sequencer: FETCH/DECODE/EXECUTE/MEMORY_ACCESS/(WRITE_BACK), 4 cycles (5 for loads) unstalled.
// Stalls on waitrequest in FETCH and on memory ops in MEMORY_ACCESS, and on alu_busy for mul/div in EXECUTE; all outputs registered.
module mips_cpu_state_sequencer #(
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [5:0]             opcode,
    input  logic [5:0]             func_code,
    input  logic                   waitrequest,
    input  logic                   alu_busy,
    input  logic                   pc_zero,
    output logic [2:0]             state,
    output logic                   active,
    output logic                   instr_done,
    output logic [COUNT_WIDTH-1:0] instr_count
);

    typedef enum logic [2:0] {
        ST_FETCH      = 3'b000,
        ST_DECODE     = 3'b001,
        ST_EXECUTE    = 3'b010,
        ST_MEM_ACCESS = 3'b011,
        ST_WRITE_BACK = 3'b100,
        ST_HALT       = 3'b101,
        ST_RESET_WAIT = 3'b110,
        ST_ILLEGAL    = 3'b111
    } state_e;

    state_e                 state_q, state_d;
    logic                   active_q;
    logic                   instr_done_q;
    logic [COUNT_WIDTH-1:0] instr_count_q;
    logic                   retire;

    logic is_load, is_store, is_mem, is_muldiv;

    assign is_load   = (opcode[5:3] == 3'b100) && (opcode[2:0] != 3'b111);
    assign is_store  = (opcode == 6'b101000) || (opcode == 6'b101001) || (opcode == 6'b101011);
    assign is_mem    = is_load || is_store;
    assign is_muldiv = (opcode == 6'b000000) && (func_code >= 6'b011000) && (func_code <= 6'b011011);

    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            ST_RESET_WAIT: state_d = ST_FETCH;
            ST_FETCH:      if (!waitrequest) state_d = ST_DECODE;
            ST_DECODE:     state_d = ST_EXECUTE;
            ST_EXECUTE:    if (!(is_muldiv && alu_busy)) state_d = ST_MEM_ACCESS;
            ST_MEM_ACCESS: begin
                if (is_mem && waitrequest) state_d = ST_MEM_ACCESS;
                else if (is_load)          state_d = ST_WRITE_BACK;
                else                       retire  = 1'b1;
            end
            ST_WRITE_BACK: retire  = 1'b1;
            ST_HALT:       state_d = ST_HALT;
            default:       state_d = ST_RESET_WAIT;
        endcase
        // pc_zero only matters on the retire edge, so a fetch from address 0 never halts.
        if (retire) state_d = pc_zero ? ST_HALT : ST_FETCH;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_RESET_WAIT;
            active_q      <= 1'b0;
            instr_done_q  <= 1'b0;
            instr_count_q <= '0;
        end else begin
            state_q      <= state_d;
            active_q     <= (state_d != ST_HALT) && (state_d != ST_RESET_WAIT);
            instr_done_q <= retire;
            if (retire) instr_count_q <= instr_count_q + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign state       = state_q;
    assign active      = active_q;
    assign instr_done  = instr_done_q;
    assign instr_count = instr_count_q;

endmodule
